// File: rtl/vec_cache_tag_wr_ctrl.sv
// Tag-SRAM write controller: queues {index, tag, way} tag updates in an in-order
// FIFO and drains them into the single-port tag SRAM in cycles the lookup pipeline
// leaves idle. If the head entry is starved too long, it forces a write and stalls
// lookups for one cycle. It also flags lookups that alias a pending or in-flight write.

// One FIFO slot: holds an entry plus its valid bit, and compares its index
// against the current lookup index.
module vec_cache_tag_wr_slot #(
    parameter int INDEX_W = 7,
    parameter int ENT_W   = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               clr_en,
    input  logic [ENT_W-1:0]   wr_data,
    input  logic [INDEX_W-1:0] lkp_index,
    output logic [ENT_W-1:0]   data,
    output logic               match
);

    logic vld;

    // Entry storage; a push and a pop never target the same slot in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            vld  <= 1'b0;
        end else begin
            if (wr_en)
                data <= wr_data;
            if (wr_en)
                vld <= 1'b1;
            else if (clr_en)
                vld <= 1'b0;
        end
    end

    // The index field sits in the top bits of the entry
    assign match = vld & (data[ENT_W-1 -: INDEX_W] == lkp_index);

endmodule

module vec_cache_tag_wr_ctrl #(
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 20,
    parameter int WAY_NUM    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8,
    localparam int WW        = $clog2(WAY_NUM),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic [INDEX_W-1:0] in_index,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [WW-1:0]      in_way,
    input  logic               lkp_req_vld,
    input  logic [INDEX_W-1:0] lkp_index,
    output logic               lkp_stall,
    output logic               lkp_pend_hit,
    output logic               tag_wr_en,
    output logic [INDEX_W-1:0] tag_wr_index,
    output logic [WW-1:0]      tag_wr_way,
    output logic [TAG_W-1:0]   tag_wr_tag,
    output logic [CW-1:0]      pend_cnt,
    output logic               idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [WW-1:0]      way;
    } wr_req_t;

    localparam int ENT_W = $bits(wr_req_t);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

    state_t                          state;
    logic [SW-1:0]                   starve_cnt;
    logic [PW-1:0]                   wr_ptr;
    logic [PW-1:0]                   rd_ptr;
    logic [CW-1:0]                   count;
    logic [CW-1:0]                   count_nxt;
    logic                            push;
    logic                            pop;
    logic                            blocked;
    wr_req_t                         in_req;
    wr_req_t                         head_req;
    logic [FIFO_DEPTH-1:0][ENT_W-1:0] slot_data;
    logic [FIFO_DEPTH-1:0]           slot_match;

    // Acceptance depends only on occupancy, so a same-cycle pop never frees a slot early
    assign in_rdy   = (count != CW'(FIFO_DEPTH));
    assign push     = in_vld & in_rdy;
    // The lookup owns the SRAM port unless this is the one-cycle forced write
    assign blocked  = lkp_req_vld & (state != S_FORCE);
    assign pop      = (count != '0) & ~blocked;
    assign in_req   = {in_index, in_tag, in_way};
    assign head_req = wr_req_t'(slot_data[rd_ptr]);

    assign lkp_stall    = (state == S_FORCE) & lkp_req_vld;
    assign lkp_pend_hit = lkp_req_vld &
                          ((|slot_match) | (tag_wr_en & (tag_wr_index == lkp_index)));
    assign pend_cnt     = count;
    assign idle         = (count == '0) & ~tag_wr_en;

    generate
        for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
            vec_cache_tag_wr_slot #(
                .INDEX_W (INDEX_W),
                .ENT_W   (ENT_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .wr_en     (push & (wr_ptr == PW'(i))),
                .clr_en    (pop & (rd_ptr == PW'(i))),
                .wr_data   (in_req),
                .lkp_index (lkp_index),
                .data      (slot_data[i]),
                .match     (slot_match[i])
            );
        end
    endgenerate

    // Next occupancy, shared by the counter and the FSM exit conditions
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

    // Starvation FSM: count blocked head cycles and force one write after STARVE_MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    starve_cnt <= '0;
                    if (count_nxt != '0)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (count_nxt == '0) begin
                        state      <= S_IDLE;
                        starve_cnt <= '0;
                    end else if (blocked && starve_cnt == SW'(STARVE_MAX - 1)) begin
                        state      <= S_FORCE;
                        starve_cnt <= '0;
                    end else if (blocked) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                S_FORCE: begin
                    starve_cnt <= '0;
                    state      <= (count_nxt != '0) ? S_WAIT : S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    // SRAM write port: popped head appears one cycle later, payload holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr_en    <= 1'b0;
            tag_wr_index <= '0;
            tag_wr_way   <= '0;
            tag_wr_tag   <= '0;
        end else begin
            tag_wr_en <= pop;
            if (pop) begin
                tag_wr_index <= head_req.index;
                tag_wr_way   <= head_req.way;
                tag_wr_tag   <= head_req.tag;
            end
        end
    end

endmodule

// File: tb/tb_vec_cache_tag_wr_ctrl.sv
// Directed bench for vec_cache_tag_wr_ctrl with a queue-based order model for
// the random traffic phase.
module tb_vec_cache_tag_wr_ctrl;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [6:0]  in_index;
    logic [19:0] in_tag;
    logic [1:0]  in_way;
    logic        lkp_req_vld;
    logic [6:0]  lkp_index;
    logic        lkp_stall;
    logic        lkp_pend_hit;
    logic        tag_wr_en;
    logic [6:0]  tag_wr_index;
    logic [1:0]  tag_wr_way;
    logic [19:0] tag_wr_tag;
    logic [2:0]  pend_cnt;
    logic        idle;

    typedef struct packed {
        logic [6:0]  index;
        logic [19:0] tag;
        logic [1:0]  way;
    } req_t;

    int   n_pass = 0;
    int   n_chk  = 0;
    req_t exp_q[$];

    vec_cache_tag_wr_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_index     (in_index),
        .in_tag       (in_tag),
        .in_way       (in_way),
        .lkp_req_vld  (lkp_req_vld),
        .lkp_index    (lkp_index),
        .lkp_stall    (lkp_stall),
        .lkp_pend_hit (lkp_pend_hit),
        .tag_wr_en    (tag_wr_en),
        .tag_wr_index (tag_wr_index),
        .tag_wr_way   (tag_wr_way),
        .tag_wr_tag   (tag_wr_tag),
        .pend_cnt     (pend_cnt),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [6:0] i, input logic [19:0] t,
                             input logic [1:0] w);
        in_vld   = v;
        in_index = i;
        in_tag   = t;
        in_way   = w;
    endtask

    initial begin
        req_t front;
        req_t last_wr;
        logic wr_now;
        logic hit_exp;
        int   run;
        int   max_run;

        rst = 1'b1;
        drive_req(1'b0, 7'd0, 20'd0, 2'd0);
        lkp_req_vld = 1'b0;
        lkp_index   = 7'd0;
        #1;
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_wr_en", 64'(tag_wr_en), 64'd0);
        chk("rst_stall", 64'(lkp_stall), 64'd0);
        chk("rst_cnt", 64'(pend_cnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: single request, lookups idle
        drive_req(1'b1, 7'd5, 20'hABCDE, 2'd2);
        settle();
        chk("t1_in_rdy", 64'(in_rdy), 64'd1);
        tick();
        in_vld = 1'b0;
        chk("t1_cnt1", 64'(pend_cnt), 64'd1);
        chk("t1_no_wr_yet", 64'(tag_wr_en), 64'd0);
        chk("t1_not_idle", 64'(idle), 64'd0);
        tick();
        chk("t1_wr_en", 64'(tag_wr_en), 64'd1);
        chk("t1_wr_idx", 64'(tag_wr_index), 64'd5);
        chk("t1_wr_tag", 64'(tag_wr_tag), 64'hABCDE);
        chk("t1_wr_way", 64'(tag_wr_way), 64'd2);
        chk("t1_cnt0", 64'(pend_cnt), 64'd0);
        tick();
        chk("t1_wr_low", 64'(tag_wr_en), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        chk("t1_hold_idx", 64'(tag_wr_index), 64'd5);

        // 2: four pushes under continuous lookups -> forced write STARVE_MAX after first push edge
        lkp_req_vld = 1'b1;
        lkp_index   = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 7'(10 + k), 20'(32'h100 + k), 2'(k));
            tick();
        end
        in_vld = 1'b0;
        chk("t2_full_rdy", 64'(in_rdy), 64'd0);
        chk("t2_full_cnt", 64'(pend_cnt), 64'd4);
        repeat (4) tick();
        chk("t2_no_stall_yet", 64'(lkp_stall), 64'd0);
        chk("t2_no_wr_yet", 64'(tag_wr_en), 64'd0);
        tick();
        chk("t2_stall", 64'(lkp_stall), 64'd1);
        chk("t2_cnt_force", 64'(pend_cnt), 64'd4);
        tick();
        chk("t2_force_wr", 64'(tag_wr_en), 64'd1);
        chk("t2_force_idx", 64'(tag_wr_index), 64'd10);
        chk("t2_force_tag", 64'(tag_wr_tag), 64'h100);
        chk("t2_stall_off", 64'(lkp_stall), 64'd0);
        chk("t2_cnt3", 64'(pend_cnt), 64'd3);
        chk("t2_rdy_again", 64'(in_rdy), 64'd1);
        lkp_req_vld = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t2_drain_en", 64'(tag_wr_en), 64'd1);
            chk("t2_drain_idx", 64'(tag_wr_index), 64'(10 + k));
            chk("t2_drain_way", 64'(tag_wr_way), 64'(k));
        end
        tick();
        chk("t2_idle", 64'(idle), 64'd1);

        // 3: pending-write hit detection through three forced writes
        lkp_req_vld = 1'b1;
        lkp_index   = 7'd3;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 7'(1 + k), 20'(32'h300 + k), 2'd1);
            settle();
            chk("t3_fill_hit", 64'(lkp_pend_hit), (k == 3) ? 64'd1 : 64'd0);
            tick();
        end
        in_vld = 1'b0;
        settle();
        chk("t3_hit_full", 64'(lkp_pend_hit), 64'd1);
        lkp_index = 7'd9;
        settle();
        chk("t3_miss", 64'(lkp_pend_hit), 64'd0);
        lkp_index = 7'd3;
        repeat (23) tick();
        chk("t3_force3_stall", 64'(lkp_stall), 64'd1);
        chk("t3_hit_popping", 64'(lkp_pend_hit), 64'd1);
        tick();
        chk("t3_wr3_en", 64'(tag_wr_en), 64'd1);
        chk("t3_wr3_idx", 64'(tag_wr_index), 64'd3);
        chk("t3_hit_inflight", 64'(lkp_pend_hit), 64'd1);
        tick();
        chk("t3_wr_low", 64'(tag_wr_en), 64'd0);
        chk("t3_hit_clear", 64'(lkp_pend_hit), 64'd0);
        chk("t3_cnt1", 64'(pend_cnt), 64'd1);
        lkp_req_vld = 1'b0;
        tick();
        chk("t3_wr4_idx", 64'(tag_wr_index), 64'd4);
        tick();
        chk("t3_idle", 64'(idle), 64'd1);

        // 4: full FIFO with in_vld and a pop in the same cycle -> no accept
        lkp_req_vld = 1'b1;
        lkp_index   = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 7'(8'h21 + k), 20'(32'h400 + k), 2'd3);
            tick();
        end
        drive_req(1'b1, 7'h55, 20'h55, 2'd1);
        lkp_req_vld = 1'b0;
        settle();
        chk("t4_full_rdy", 64'(in_rdy), 64'd0);
        tick();
        in_vld = 1'b0;
        chk("t4_cnt3", 64'(pend_cnt), 64'd3);
        chk("t4_rdy", 64'(in_rdy), 64'd1);
        chk("t4_wr_idx0", 64'(tag_wr_index), 64'h21);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t4_drain_idx", 64'(tag_wr_index), 64'(8'h21 + k));
        end
        tick();
        chk("t4_idle", 64'(idle), 64'd1);
        chk("t4_last_idx", 64'(tag_wr_index), 64'h24);

        // 5: random traffic against an in-order queue model
        run     = 0;
        max_run = 0;
        for (int c = 0; c < 10008; c++) begin
            @(posedge clk);
            #1;
            wr_now = 1'b0;
            if (tag_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("t5_spurious_wr", 64'(tag_wr_en), 64'd0);
                end else begin
                    front = exp_q.pop_front();
                    chk("t5_wr_order", 64'({tag_wr_index, tag_wr_tag, tag_wr_way}), 64'(front));
                    last_wr = front;
                    wr_now  = 1'b1;
                end
            end
            chk("t5_cnt", 64'(pend_cnt), 64'(exp_q.size()));
            if (c < 10000) begin
                drive_req($urandom_range(0, 1) == 1, 7'($urandom_range(0, 7)),
                          20'($urandom), 2'($urandom_range(0, 3)));
                lkp_req_vld = $urandom_range(0, 9) < 7;
                lkp_index   = 7'($urandom_range(0, 7));
            end else begin
                in_vld      = 1'b0;
                lkp_req_vld = 1'b0;
            end
            #1;
            hit_exp = wr_now && (last_wr.index == lkp_index);
            foreach (exp_q[i])
                if (exp_q[i].index == lkp_index)
                    hit_exp = 1'b1;
            hit_exp = hit_exp & lkp_req_vld;
            chk("t5_hit", 64'(lkp_pend_hit), 64'(hit_exp));
            chk("t5_rdy", 64'(in_rdy), 64'(exp_q.size() != 4));
            if (exp_q.size() != 0 && lkp_req_vld && !lkp_stall)
                run++;
            else
                run = 0;
            if (run > max_run)
                max_run = run;
            if (in_vld && exp_q.size() != 4)
                exp_q.push_back({in_index, in_tag, in_way});
        end
        chk("t5_starve_bound", 64'(max_run <= 8), 64'd1);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);
        tick();
        chk("t5_idle", 64'(idle), 64'd1);

        // 6: reset with three pending writes
        lkp_req_vld = 1'b1;
        lkp_index   = 7'h7F;
        for (int k = 0; k < 3; k++) begin
            drive_req(1'b1, 7'(8'h31 + k), 20'(32'h600 + k), 2'd2);
            tick();
        end
        in_vld    = 1'b0;
        lkp_index = 7'h32;
        settle();
        chk("t6_cnt3", 64'(pend_cnt), 64'd3);
        chk("t6_hit_before", 64'(lkp_pend_hit), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_cnt", 64'(pend_cnt), 64'd0);
        chk("t6_rdy", 64'(in_rdy), 64'd1);
        chk("t6_idle", 64'(idle), 64'd1);
        chk("t6_wr_en", 64'(tag_wr_en), 64'd0);
        chk("t6_stall", 64'(lkp_stall), 64'd0);
        chk("t6_hit", 64'(lkp_pend_hit), 64'd0);
        chk("t6_payload", 64'({tag_wr_index, tag_wr_tag, tag_wr_way}), 64'd0);
        tick();
        rst         = 1'b0;
        lkp_req_vld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_no_wr", 64'(tag_wr_en), 64'd0);
        end
        chk("t6_idle_after", 64'(idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
